// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and a multi-cycle signed shift-add multiplier.
// Optional feature: define ALU_SAT_EN to saturate add/sub results on signed overflow.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             equal
);

  localparam int PW  = 2 * WIDTH;
  localparam int MSB = WIDTH - 1;
  localparam int CW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(2);
  localparam logic [OPW-1:0] OP_AND  = OPW'(3);
  localparam logic [OPW-1:0] OP_OR   = OPW'(4);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(5);
  localparam logic [OPW-1:0] OP_SLT  = OPW'(6);
  localparam logic [OPW-1:0] OP_EQ   = OPW'(7);
  localparam logic [OPW-1:0] OP_SLTU = OPW'(8);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(9);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_ovf;
  logic             r_zero;
  logic             r_equal;

  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_acc;
  logic [CW-1:0]    r_step;
  logic             r_mul_eq;

  logic             w_accept;
  logic             w_is_mul;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_alu_result;
  logic             w_alu_carry;
  logic             w_alu_ovf;
  logic             w_step_last;
  logic [PW-1:0]    w_pp;
  logic [PW-1:0]    w_acc_next;
  logic             w_mul_ovf;

  assign w_is_mul = (opcode == OP_MUL);
  assign w_accept = in_valid & in_ready;

  // Control: state register plus combinational next-state and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = ~rst;
        if (in_valid & ~rst) begin
          w_state_next = w_is_mul ? S_BUSY : S_DONE;
        end
      end
      S_BUSY: begin
        if (w_step_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready & ~rst;
        if (out_ready) begin
          if (in_valid) begin
            w_state_next = w_is_mul ? S_BUSY : S_DONE;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Single-cycle operations, evaluated on the live inputs and captured at accept.
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    w_alu_result = '0;
    w_alu_carry  = 1'b0;
    w_alu_ovf    = 1'b0;
    case (opcode)
      OP_ADD: begin
        w_alu_result = w_sum[WIDTH-1:0];
        w_alu_carry  = w_sum[WIDTH];
        w_alu_ovf    = (a[MSB] == b[MSB]) & (w_sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        w_alu_result = w_diff[WIDTH-1:0];
        w_alu_carry  = w_diff[WIDTH];
        w_alu_ovf    = (a[MSB] != b[MSB]) & (w_diff[MSB] != a[MSB]);
      end
      OP_NOT:  w_alu_result = ~a;
      OP_AND:  w_alu_result = a & b;
      OP_OR:   w_alu_result = a | b;
      OP_XOR:  w_alu_result = a ^ b;
      OP_SLT:  w_alu_result = WIDTH'($signed(a) < $signed(b));
      OP_EQ:   w_alu_result = WIDTH'(a == b);
      OP_SLTU: w_alu_result = WIDTH'(a < b);
      default: w_alu_result = '0;
    endcase
`ifdef ALU_SAT_EN
    // Clamp toward the sign of a; the overflow flag still reports the event.
    if (((opcode == OP_ADD) || (opcode == OP_SUB)) && w_alu_ovf) begin
      w_alu_result = a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Multiplier step: the last multiplier bit carries negative weight, so WIDTH
  // steps yield the exact 2*WIDTH-bit signed product.
  assign w_step_last = (r_state == S_BUSY) && (r_step == CW'(WIDTH - 1));
  assign w_pp        = r_mplier[0] ? r_mcand : '0;
  assign w_acc_next  = w_step_last ? (r_acc - w_pp) : (r_acc + w_pp);
  assign w_mul_ovf   = (w_acc_next[PW-1:MSB] != {(WIDTH+1){w_acc_next[MSB]}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
      r_equal  <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_step   <= '0;
      r_mul_eq <= 1'b0;
    end else if (w_accept) begin
      if (w_is_mul) begin
        r_mcand  <= {{WIDTH{a[MSB]}}, a};
        r_mplier <= b;
        r_acc    <= '0;
        r_step   <= '0;
        r_mul_eq <= (a == b);
      end else begin
        r_result <= w_alu_result;
        r_carry  <= w_alu_carry;
        r_ovf    <= w_alu_ovf;
        r_zero   <= (w_alu_result == '0);
        r_equal  <= (a == b);
      end
    end else if (r_state == S_BUSY) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_step   <= r_step + CW'(1);
      if (w_step_last) begin
        r_result <= w_acc_next[WIDTH-1:0];
        r_carry  <= 1'b0;
        r_ovf    <= w_mul_ovf;
        r_zero   <= (w_acc_next[WIDTH-1:0] == '0);
        r_equal  <= r_mul_eq;
      end
    end
  end

  assign result    = r_result;
  assign carry_out = r_carry;
  assign overflow  = r_ovf;
  assign zero      = r_zero;
  assign equal     = r_equal;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): arithmetic reference model with a
// result queue, plus directed literal checks for latency, hold, back-to-back and reset.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;
  logic         equal;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
    logic         e;
  } exp_t;

  exp_t exp_q[$];

  alu_seq #(.WIDTH(W), .OPW(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .overflow(overflow),
    .zero(zero), .equal(equal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [W-1:0] ua, input logic [W-1:0] ub, input logic [3:0] op);
    exp_t   x;
    longint sa, sb, uai, ubi, r, maxs, mins;
    sa   = longint'($signed(ua));
    sb   = longint'($signed(ub));
    uai  = longint'(ua);
    ubi  = longint'(ub);
    maxs = (64'sd1 <<< (W - 1)) - 1;
    mins = -(64'sd1 <<< (W - 1));
    x = '0;
    r = 0;
    case (int'(op))
      0: begin
        r = uai + ubi;
        x.c = (uai + ubi) >= (64'sd1 <<< W);
        x.v = (sa + sb > maxs) || (sa + sb < mins);
`ifdef ALU_SAT_EN
        if (x.v) r = (sa < 0) ? mins : maxs;
`endif
      end
      1: begin
        r = uai - ubi;
        x.c = uai < ubi;
        x.v = (sa - sb > maxs) || (sa - sb < mins);
`ifdef ALU_SAT_EN
        if (x.v) r = (sa < 0) ? mins : maxs;
`endif
      end
      2: r = longint'(~ua);
      3: r = longint'(ua & ub);
      4: r = longint'(ua | ub);
      5: r = longint'(ua ^ ub);
      6: r = (sa < sb) ? 1 : 0;
      7: r = (ua == ub) ? 1 : 0;
      8: r = (uai < ubi) ? 1 : 0;
      9: begin
        r = sa * sb;
        x.v = (r > maxs) || (r < mins);
      end
      default: r = 0;
    endcase
    x.res = r[W-1:0];
    x.z   = (x.res == '0);
    x.e   = (ua == ub);
    return x;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Compare process: every cycle a result is presented, it must match the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got result=%h with no pending operation", result);
      end else begin
        check("model_result",   32'(result),    32'(exp_q[0].res));
        check("model_carry",    32'(carry_out), 32'(exp_q[0].c));
        check("model_overflow", 32'(overflow),  32'(exp_q[0].v));
        check("model_zero",     32'(zero),      32'(exp_q[0].z));
        check("model_equal",    32'(equal),     32'(exp_q[0].e));
        if (out_ready) begin
          $display("txn result=%h c=%b v=%b z=%b e=%b", result, carry_out, overflow, zero, equal);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Present one operation, wait (bounded) for acceptance, queue its expectation.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic [3:0] top);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    a        = ta;
    b        = tb2;
    opcode   = top;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 50 cycles");
    end
    @(posedge clk);
    if (ok) exp_q.push_back(model(ta, tb2, top));
    #1;
    in_valid = 1'b0;
  endtask

  typedef struct packed {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [3:0]   vop;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV] = '{
    '{8'hA5, 8'h0F, 4'd2}, '{8'hA5, 8'h0F, 4'd3}, '{8'hA5, 8'h0F, 4'd4},
    '{8'hA5, 8'hA5, 4'd5}, '{8'h80, 8'h7F, 4'd6}, '{8'h10, 8'h20, 4'd8},
    '{8'hFF, 8'h01, 4'd0}, '{8'h80, 8'hFF, 4'd0}, '{8'h7F, 8'h7F, 4'd9},
    '{8'h80, 8'h80, 4'd9}, '{8'h12, 8'h34, 4'd11}, '{8'h55, 8'h55, 4'd15}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; opcode = '0;

    // Reset behaviour
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready",  32'(in_ready),  32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_outputs",   32'({result, carry_out, overflow, zero, equal}), 32'd0);

    // add with signed overflow, latency 1
    @(posedge clk); #1;
    send(8'h7F, 8'h01, 4'd0);
    @(negedge clk);
    check("add_valid", 32'(out_valid), 32'd1);
`ifdef ALU_SAT_EN
    check("add_result", 32'(result), 32'h7F);
`else
    check("add_result", 32'(result), 32'h80);
`endif
    check("add_ovf",   32'(overflow),  32'd1);
    check("add_carry", 32'(carry_out), 32'd0);
    check("add_zero",  32'(zero),      32'd0);

    // subtraction borrow and overflow
    @(posedge clk); #1;
    send(8'h00, 8'h01, 4'd1);
    @(negedge clk);
    check("sub0_result", 32'(result),    32'hFF);
    check("sub0_borrow", 32'(carry_out), 32'd1);
    check("sub0_ovf",    32'(overflow),  32'd0);
    @(posedge clk); #1;
    send(8'h80, 8'h01, 4'd1);
    @(negedge clk);
`ifdef ALU_SAT_EN
    check("sub1_result", 32'(result), 32'h80);
`else
    check("sub1_result", 32'(result), 32'h7F);
`endif
    check("sub1_ovf", 32'(overflow), 32'd1);

    // mul latency: 8 busy cycles, result on the 9th
    @(posedge clk); #1;
    send(8'hFD, 8'h05, 4'd9);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("mul_busy%0d_in_ready", k), 32'(in_ready), 32'd0);
      check($sformatf("mul_busy%0d_out_valid", k), 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    check("mul_valid",  32'(out_valid), 32'd1);
    check("mul_result", 32'(result),    32'hF1);
    check("mul_ovf",    32'(overflow),  32'd0);

    @(posedge clk); #1;
    send(8'h80, 8'hFF, 4'd9);
    repeat (9) @(negedge clk);
    check("mulmin_result", 32'(result),   32'h80);
    check("mulmin_ovf",    32'(overflow), 32'd1);

    // compares
    @(posedge clk); #1;
    send(8'hFF, 8'h01, 4'd6);
    @(negedge clk);
    check("slt_result", 32'(result), 32'd1);
    @(posedge clk); #1;
    send(8'hFF, 8'h01, 4'd8);
    @(negedge clk);
    check("sltu_result", 32'(result), 32'd0);
    @(posedge clk); #1;
    send(8'h3C, 8'h3C, 4'd7);
    @(negedge clk);
    check("eq_result", 32'(result), 32'd1);
    check("eq_equal",  32'(equal),  32'd1);

    // hold under backpressure, then back-to-back accept
    @(posedge clk); #1 out_ready = 1'b0;
    send(8'h12, 8'h34, 4'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d_result", k), 32'(result), 32'h46);
      check($sformatf("hold%0d_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d_in_ready", k), 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    send(8'h5A, 8'h0F, 4'd5);
    @(negedge clk);
    check("b2b_valid",  32'(out_valid), 32'd1);
    check("b2b_result", 32'(result),    32'h55);

    // table-driven vectors checked by the model only
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      send(vecs[i].va, vecs[i].vb, vecs[i].vop);
    end
    repeat (12) @(negedge clk);

    // reset during the 4th busy cycle abandons the product
    @(posedge clk); #1;
    send(8'h07, 8'h09, 4'd9);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_outputs",   32'({result, carry_out, overflow, zero, equal}), 32'd0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("midrst_no_result", 32'(out_valid), 32'd0);
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
